// File: rtl/mips_pkg.sv
// Shared types for the pipeline hazard / run-control unit: FSM state
// encoding, the "no forwarding" select value and the scoreboard entry flags.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } pipe_state_e;

  // Operand taken from the regfile / ID-EX latch, no bypass.
  localparam int FWD_REGFILE = 0;

  // Per-stage scoreboard flags; the destination register travels beside
  // these in its own NB_REG-wide field because the width is a parameter.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
  } sb_flags_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight instruction tracker: one entry per post-decode stage, entry 0 is
// EX. Shifts on every pipeline advance. kill1_i squashes the instruction that
// is leaving EX (taken-branch flush of the EX/MEM latch).
import mips_pkg::*;

module pipe_scoreboard #(
  parameter int NB_REG   = 5,
  parameter int N_STAGES = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               adv_i,
  input  logic                               kill1_i,
  input  sb_flags_t                          flags_i,
  input  logic [NB_REG-1:0]                  dest_i,
  output logic [N_STAGES-1:0]                valid_o,
  output logic [N_STAGES-1:0]                regwrite_o,
  output logic [N_STAGES-1:0]                memread_o,
  output logic [N_STAGES-1:0][NB_REG-1:0]    dest_o
);

  sb_flags_t [N_STAGES-1:0]             flags_q, flags_d;
  logic      [N_STAGES-1:0][NB_REG-1:0] dest_q,  dest_d;

  // Next state: shift by one stage on advance, new instruction into EX.
  always_comb begin
    flags_d = flags_q;
    dest_d  = dest_q;
    if (adv_i) begin
      flags_d[0] = flags_i;
      dest_d[0]  = dest_i;
      for (int k = 1; k < N_STAGES; k++) begin
        flags_d[k] = flags_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      if (kill1_i) flags_d[1] = '0;
    end
  end

  // Entry storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      dest_q  <= '0;
    end else begin
      flags_q <= flags_d;
      dest_q  <= dest_d;
    end
  end

  // Unpack the entries into per-field vectors for the match logic.
  always_comb begin
    valid_o    = '0;
    regwrite_o = '0;
    memread_o  = '0;
    dest_o     = dest_q;
    for (int k = 0; k < N_STAGES; k++) begin
      valid_o[k]    = flags_q[k].valid;
      regwrite_o[k] = flags_q[k].regwrite;
      memread_o[k]  = flags_q[k].memread;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and run-control unit for the 5-stage pipeline: load-use stall,
// branch/jump flush, registered forwarding selects and a RUN/DRAIN/HALT/STEP
// controller. Build option PIPE_CTRL_DEBUG_EN enables the dbg_step/dbg_run
// exits from HALT; without it HALT is left only through reset.
// N_STAGES must be at least 2.
import mips_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int NB_REG   = 5,
  parameter int N_STAGES = 3,
  parameter int NB_FWD   = $clog2(N_STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_id_valid,
  input  logic [NB_REG-1:0] in_id_rs,
  input  logic [NB_REG-1:0] in_id_rt,
  input  logic              in_id_uses_rs,
  input  logic              in_id_uses_rt,
  input  logic [NB_REG-1:0] in_id_dest,
  input  logic              in_id_regwrite,
  input  logic              in_id_memread,
  input  logic              in_id_jump,
  input  logic              in_id_halt,
  input  logic              in_branch_taken,
  input  logic              dbg_step,
  input  logic              dbg_run,
  output logic              out_pc_write,
  output logic              out_ifid_write,
  output logic              out_pipe_en,
  output logic              out_idex_bubble,
  output logic              out_flush_ifid,
  output logic              out_flush_idex,
  output logic              out_flush_exmem,
  output logic [NB_FWD-1:0] out_fwd_a,
  output logic [NB_FWD-1:0] out_fwd_b,
  output logic              out_halted,
  output logic [1:0]        out_state
);

  pipe_state_e state_q, state_d;

  logic [N_STAGES-1:0]             sb_valid, sb_regwr, sb_memrd;
  logic [N_STAGES-1:0][NB_REG-1:0] sb_dest;

  logic accept, br_act, halt_dec, stall, jump_fl, push_valid, drained;
  logic hit_rs, hit_rt;
  logic [NB_FWD-1:0] sel_a, sel_b, fwd_a_q, fwd_b_q;
  sb_flags_t push_flags;

`ifndef PIPE_CTRL_DEBUG_EN
  logic dbg_unused;
  assign dbg_unused = dbg_step | dbg_run;
`endif

  // Hazard detection from the EX-side scoreboard and the decode instruction.
  // Only RUN and STEP accept decode; DRAIN and HALT ignore whatever is held there.
  always_comb begin
    accept  = (state_q == ST_RUN) || (state_q == ST_STEP);
    br_act  = in_branch_taken && (state_q != ST_HALT);
    hit_rs  = in_id_uses_rs && sb_valid[0] && sb_memrd[0] &&
              (sb_dest[0] != '0) && (sb_dest[0] == in_id_rs);
    hit_rt  = in_id_uses_rt && sb_valid[0] && sb_memrd[0] &&
              (sb_dest[0] != '0) && (sb_dest[0] == in_id_rt);
    halt_dec   = accept && in_id_valid && in_id_halt && !br_act;
    stall      = accept && in_id_valid && (hit_rs || hit_rt) && !br_act && !halt_dec;
    jump_fl    = accept && in_id_valid && in_id_jump && !br_act && !stall && !halt_dec;
    push_valid = accept && in_id_valid && !br_act && !stall && !halt_dec;
    // Entry N_STAGES-1 retires this cycle, so the pipe is empty after the
    // next advance once the younger entries are all bubbles.
    drained    = ~|sb_valid[N_STAGES-2:0];
    push_flags.valid    = push_valid;
    push_flags.regwrite = push_valid && in_id_regwrite;
    push_flags.memread  = push_valid && in_id_memread;
  end

  // Forwarding priority: nearest producer (lowest entry index) wins.
  always_comb begin
    sel_a = NB_FWD'(FWD_REGFILE);
    sel_b = NB_FWD'(FWD_REGFILE);
    for (int i = N_STAGES-2; i >= 0; i--) begin
      if (in_id_uses_rs && (in_id_rs != '0) && sb_valid[i] && sb_regwr[i] &&
          (sb_dest[i] == in_id_rs))
        sel_a = NB_FWD'(i+1);
      if (in_id_uses_rt && (in_id_rt != '0) && sb_valid[i] && sb_regwr[i] &&
          (sb_dest[i] == in_id_rt))
        sel_b = NB_FWD'(i+1);
    end
  end

  // Run-control FSM next state and all enable/flush outputs. Reset low
  // forces the reset values without waiting for a clock edge.
  always_comb begin
    state_d         = state_q;
    out_pc_write    = 1'b1;
    out_ifid_write  = 1'b1;
    out_pipe_en     = 1'b1;
    out_idex_bubble = 1'b0;
    out_flush_ifid  = 1'b0;
    out_flush_idex  = 1'b0;
    out_flush_exmem = 1'b0;
    out_halted      = 1'b0;
    if (reset) begin
      case (state_q)
        ST_RUN, ST_STEP: begin
          if (br_act) begin
            out_flush_ifid  = 1'b1;
            out_flush_idex  = 1'b1;
            out_flush_exmem = 1'b1;
          end else if (halt_dec) begin
            out_pc_write    = 1'b0;
            out_ifid_write  = 1'b0;
            out_idex_bubble = 1'b1;
          end else if (stall) begin
            out_pc_write    = 1'b0;
            out_ifid_write  = 1'b0;
            out_idex_bubble = 1'b1;
          end else if (jump_fl) begin
            out_flush_ifid  = 1'b1;
          end
          if (halt_dec)                state_d = ST_DRAIN;
          else if (state_q == ST_STEP) state_d = ST_HALT;
        end
        ST_DRAIN: begin
          // An older taken branch means the HALT was on the wrong path:
          // redirect and resume instead of halting.
          if (br_act) begin
            out_flush_ifid  = 1'b1;
            out_flush_idex  = 1'b1;
            out_flush_exmem = 1'b1;
            state_d         = ST_RUN;
          end else begin
            out_pc_write    = 1'b0;
            out_ifid_write  = 1'b0;
            out_idex_bubble = 1'b1;
            if (drained) state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          out_pc_write   = 1'b0;
          out_ifid_write = 1'b0;
          out_pipe_en    = 1'b0;
          out_halted     = 1'b1;
`ifdef PIPE_CTRL_DEBUG_EN
          if (dbg_run)       state_d = ST_RUN;
          else if (dbg_step) state_d = ST_STEP;
`endif
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Forwarding selects follow the instruction into EX; held while frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a_q <= NB_FWD'(FWD_REGFILE);
      fwd_b_q <= NB_FWD'(FWD_REGFILE);
    end else if (out_pipe_en) begin
      fwd_a_q <= push_valid ? sel_a : NB_FWD'(FWD_REGFILE);
      fwd_b_q <= push_valid ? sel_b : NB_FWD'(FWD_REGFILE);
    end
  end

  assign out_fwd_a = fwd_a_q;
  assign out_fwd_b = fwd_b_q;
  assign out_state = state_q;

  pipe_scoreboard #(
    .NB_REG   (NB_REG),
    .N_STAGES (N_STAGES)
  ) u_sb (
    .clk        (clk),
    .rst_n      (reset),
    .adv_i      (out_pipe_en),
    .kill1_i    (br_act),
    .flags_i    (push_flags),
    .dest_i     (in_id_dest),
    .valid_o    (sb_valid),
    .regwrite_o (sb_regwr),
    .memread_o  (sb_memrd),
    .dest_o     (sb_dest)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl (default parameters, N_STAGES=3).
// Expected forwarding selects are queued when an instruction is presented in
// decode and popped after the edge that moves it into EX.
module tb_pipeline_hazard_ctrl;

  logic       clk, reset;
  logic       in_id_valid, in_id_uses_rs, in_id_uses_rt;
  logic [4:0] in_id_rs, in_id_rt, in_id_dest;
  logic       in_id_regwrite, in_id_memread, in_id_jump, in_id_halt;
  logic       in_branch_taken, dbg_step, dbg_run;
  logic       out_pc_write, out_ifid_write, out_pipe_en, out_idex_bubble;
  logic       out_flush_ifid, out_flush_idex, out_flush_exmem, out_halted;
  logic [1:0] out_fwd_a, out_fwd_b, out_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  logic [2:0] stall_v, fl_v;
  logic [9:0] outs;
  localparam logic [9:0] RST_OUTS = {3'b111, 4'b0000, 1'b0, 2'b00};

  assign stall_v = {out_pc_write, out_ifid_write, out_idex_bubble};
  assign fl_v    = {out_flush_ifid, out_flush_idex, out_flush_exmem};
  assign outs    = {out_pc_write, out_ifid_write, out_pipe_en, out_idex_bubble,
                    out_flush_ifid, out_flush_idex, out_flush_exmem, out_halted, out_state};

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .in_id_valid(in_id_valid), .in_id_rs(in_id_rs), .in_id_rt(in_id_rt),
    .in_id_uses_rs(in_id_uses_rs), .in_id_uses_rt(in_id_uses_rt),
    .in_id_dest(in_id_dest), .in_id_regwrite(in_id_regwrite), .in_id_memread(in_id_memread),
    .in_id_jump(in_id_jump), .in_id_halt(in_id_halt), .in_branch_taken(in_branch_taken),
    .dbg_step(dbg_step), .dbg_run(dbg_run),
    .out_pc_write(out_pc_write), .out_ifid_write(out_ifid_write), .out_pipe_en(out_pipe_en),
    .out_idex_bubble(out_idex_bubble), .out_flush_ifid(out_flush_ifid),
    .out_flush_idex(out_flush_idex), .out_flush_exmem(out_flush_exmem),
    .out_fwd_a(out_fwd_a), .out_fwd_b(out_fwd_b), .out_halted(out_halted), .out_state(out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] dst, input logic rw, input logic mr);
    in_id_valid = v; in_id_rs = rs; in_id_uses_rs = urs; in_id_rt = rt; in_id_uses_rt = urt;
    in_id_dest = dst; in_id_regwrite = rw; in_id_memread = mr;
    in_id_jump = 1'b0; in_id_halt = 1'b0; in_branch_taken = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    dbg_step = 1'b0; dbg_run = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic flush_pipe();
    idle();
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0; #1; reset = 1'b1; #1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #3;
    n_cmp++; if (outs !== RST_OUTS) begin n_mis++; $display("FAIL reset_outs: got %b expected %b", outs, RST_OUTS); end
    repeat (2) tick();
    n_cmp++; if ({out_fwd_a, out_fwd_b, outs} !== {4'h0, RST_OUTS}) begin n_mis++; $display("FAIL reset_hold: got %b expected %b", {out_fwd_a, out_fwd_b, outs}, {4'h0, RST_OUTS}); end
    reset = 1'b1; #1;
    tick();
  endtask

  task automatic test_load_use();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd2, 1, 1); #1;            // lw $2,0($7)
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL lu_lw_nostall: got %b expected 110", stall_v); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL lu_fwd_lw: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0); #1;            // add $3,$2,$4
    n_cmp++; if (stall_v !== 3'b001) begin n_mis++; $display("FAIL lu_stall: got %b expected 001", stall_v); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL lu_fwd_bubble: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    #1;
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL lu_one_cycle: got %b expected 110", stall_v); end
    exp_q.push_back({2'd2, 2'd0}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL lu_fwd_memwb: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    flush_pipe();
  endtask

  task automatic test_forward();
    drive(1, 5'd8, 1, 5'd9, 1, 5'd1, 1, 0);                 // add $1,$8,$9
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_add1: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd1, 1, 5'd1, 1, 5'd5, 1, 0); #1;            // sub $5,$1,$1
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL fwd_nostall: got %b expected 110", stall_v); end
    exp_q.push_back({2'd1, 2'd1}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_ex_ab: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd9, 1, 5'd10, 1, 5'd1, 1, 0); tick();        // add $1 (older)
    drive(1, 5'd11, 1, 5'd0, 0, 5'd1, 1, 0); tick();        // add $1 (newer)
    drive(1, 5'd1, 1, 5'd6, 1, 5'd7, 1, 0);                 // add $7,$1,$6
    exp_q.push_back({2'd1, 2'd0}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_nearest: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    idle();
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_nop: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd0, 0, 5'd7, 1, 5'd12, 1, 0);                // rt=$7 two stages back
    exp_q.push_back({2'd0, 2'd2}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_b_dist2: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    flush_pipe();
    drive(1, 5'd0, 1, 5'd0, 0, 5'd6, 1, 1); tick();         // lw $6
    idle(); tick();
    drive(1, 5'd6, 1, 5'd0, 0, 5'd13, 1, 0); #1;           // use $6 after one gap
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL fwd_load_gap_nostall: got %b expected 110", stall_v); end
    exp_q.push_back({2'd2, 2'd0}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL fwd_load_gap: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    flush_pipe();
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd8, 1, 5'd9, 1, 5'd0, 1, 0); tick();         // add $0
    drive(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0); #1;            // use $0,$0
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL zero_nostall: got %b expected 110", stall_v); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL zero_fwd: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd8, 1, 5'd0, 0, 5'd0, 1, 1); tick();         // lw $0
    drive(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0); #1;
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL zero_load_nostall: got %b expected 110", stall_v); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL zero_load_fwd: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    flush_pipe();
  endtask

  task automatic test_branch_jump();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd2, 1, 1); tick();         // lw $2
    drive(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0);                 // dependent add
    in_branch_taken = 1'b1; #1;
    n_cmp++; if ({stall_v, fl_v} !== 6'b110_111) begin n_mis++; $display("FAIL br_over_stall: got %b expected 110111", {stall_v, fl_v}); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL br_fwd: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd2, 1, 5'd4, 1, 5'd3, 1, 0); #1;            // squashed load must not hit
    n_cmp++; if ({stall_v, fl_v} !== 6'b110_000) begin n_mis++; $display("FAIL br_one_cycle: got %b expected 110000", {stall_v, fl_v}); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL br_load_killed: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    in_id_jump = 1'b1; #1;
    n_cmp++; if ({stall_v, fl_v} !== 6'b110_100) begin n_mis++; $display("FAIL jump_flush: got %b expected 110100", {stall_v, fl_v}); end
    tick();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd2, 1, 1); tick();         // lw $2
    drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 0);
    in_id_jump = 1'b1; #1;                                  // jump-register stalled
    n_cmp++; if ({stall_v, fl_v} !== 6'b001_000) begin n_mis++; $display("FAIL jump_during_stall: got %b expected 001000", {stall_v, fl_v}); end
    tick(); #1;
    n_cmp++; if ({stall_v, fl_v} !== 6'b110_100) begin n_mis++; $display("FAIL jump_after_stall: got %b expected 110100", {stall_v, fl_v}); end
    flush_pipe();
  endtask

  task automatic test_halt_debug();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd8, 1, 5'd9, 1, 5'd20, 1, 0); tick();
    end
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    in_id_halt = 1'b1; #1;
    n_cmp++; if ({stall_v, out_state} !== 5'b001_00) begin n_mis++; $display("FAIL halt_bubble: got %b expected 00100", {stall_v, out_state}); end
    tick(); idle(); #1;
    n_cmp++; if ({out_halted, out_state, stall_v} !== 6'b0_01_001) begin n_mis++; $display("FAIL drain_c1: got %b expected 001001", {out_halted, out_state, stall_v}); end
    tick(); #1;
    n_cmp++; if ({out_halted, out_state} !== 3'b0_01) begin n_mis++; $display("FAIL drain_c2: got %b expected 001", {out_halted, out_state}); end
    tick(); #1;
    n_cmp++; if ({out_halted, out_state, out_pipe_en, out_pc_write, out_ifid_write} !== 6'b1_10_000) begin n_mis++; $display("FAIL halt_c3: got %b expected 110000", {out_halted, out_state, out_pipe_en, out_pc_write, out_ifid_write}); end
`ifdef PIPE_CTRL_DEBUG_EN
    dbg_step = 1'b1; tick(); dbg_step = 1'b0; #1;
    n_cmp++; if ({out_state, out_pipe_en, out_pc_write, out_ifid_write} !== 5'b11_111) begin n_mis++; $display("FAIL step_cycle: got %b expected 11111", {out_state, out_pipe_en, out_pc_write, out_ifid_write}); end
    tick(); #1;
    n_cmp++; if ({out_state, out_pipe_en, out_halted} !== 4'b10_01) begin n_mis++; $display("FAIL step_return: got %b expected 1001", {out_state, out_pipe_en, out_halted}); end
    dbg_step = 1'b1; dbg_run = 1'b1; tick(); dbg_step = 1'b0; dbg_run = 1'b0; #1;
    n_cmp++; if ({out_state, out_halted, out_pipe_en} !== 4'b00_01) begin n_mis++; $display("FAIL run_wins: got %b expected 0001", {out_state, out_halted, out_pipe_en}); end
`else
    dbg_run = 1'b1; tick(); dbg_run = 1'b0; #1;
    n_cmp++; if ({out_state, out_halted, out_pipe_en} !== 4'b10_10) begin n_mis++; $display("FAIL run_ignored: got %b expected 1010", {out_state, out_halted, out_pipe_en}); end
    dbg_step = 1'b1; tick(); dbg_step = 1'b0; #1;
    n_cmp++; if ({out_state, out_halted, out_pipe_en} !== 4'b10_10) begin n_mis++; $display("FAIL step_ignored: got %b expected 1010", {out_state, out_halted, out_pipe_en}); end
`endif
    apply_reset();
  endtask

  task automatic test_reset_mid();
    drive(1, 5'd7, 1, 5'd0, 0, 5'd2, 1, 1); tick();         // lw $2
    drive(1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 0); #1;            // add $3,$2
    n_cmp++; if (stall_v !== 3'b001) begin n_mis++; $display("FAIL rst_pre_stall: got %b expected 001", stall_v); end
    reset = 1'b0; #1;
    n_cmp++; if ({out_fwd_a, out_fwd_b, outs} !== {4'h0, RST_OUTS}) begin n_mis++; $display("FAIL rst_mid_stall: got %b expected %b", {out_fwd_a, out_fwd_b, outs}, {4'h0, RST_OUTS}); end
    reset = 1'b1; #1;
    n_cmp++; if (stall_v !== 3'b110) begin n_mis++; $display("FAIL rst_release_nostall: got %b expected 110", stall_v); end
    exp_q.push_back(4'h0); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL rst_first_fwd: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0);                 // uses $3 from the add
    exp_q.push_back({2'd1, 2'd0}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL rst_first_adv: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    drive(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    in_id_halt = 1'b1; tick(); idle(); #1;
    n_cmp++; if (out_state !== 2'b01) begin n_mis++; $display("FAIL rst_pre_drain: got %b expected 01", out_state); end
    reset = 1'b0; #1;
    n_cmp++; if (outs !== RST_OUTS) begin n_mis++; $display("FAIL rst_mid_drain: got %b expected %b", outs, RST_OUTS); end
    reset = 1'b1; #1;
    drive(1, 5'd8, 1, 5'd0, 0, 5'd4, 1, 0); tick();         // add $4
    drive(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0); #1;
    n_cmp++; if ({out_pipe_en, stall_v} !== 4'b1_110) begin n_mis++; $display("FAIL rst_drain_resume: got %b expected 1110", {out_pipe_en, stall_v}); end
    exp_q.push_back({2'd1, 2'd0}); tick();
    e = exp_q.pop_front(); n_cmp++; if ({out_fwd_a, out_fwd_b} !== e) begin n_mis++; $display("FAIL rst_drain_fwd: got %h expected %h", {out_fwd_a, out_fwd_b}, e); end
    flush_pipe();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_zero_reg();
    test_branch_jump();
    test_halt_debug();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
